// File: rtl/multdiv_sequencer.sv
// -----------------------------------------------------------------------------
// multdiv_sequencer
//
// Front end for the shared iterative multiply/divide unit in the single-issue
// datapath. It takes a decoded mult/div issue, latches the operands (holding
// them stable for the unit), fires a one-cycle start pulse, counts the unit
// latency while stalling the pipeline, then presents one writeback beat.
// That beat carries the result, the destination register and the rstatus
// exception code.
//
// Optional feature (compile-time macro MULTDIV_EARLY_DONE_EN):
//   When defined, the unit_ready port exists. RUN then ends on unit_ready or
//   on the terminal count, whichever comes first. unit_ready is ignored in
//   the first RUN cycle. When undefined, only the fixed latency count is used.
//
// Parameters:
//   MULT_CYCLES  cycles the unit needs for mult (>= 1)
//   DIV_CYCLES   cycles the unit needs for div  (>= 1)
//   CNT_W        counter width; must hold max(MULT_CYCLES, DIV_CYCLES) - 1
//
// Ports:
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   issue_valid  in   decoded instruction is mult/div this cycle
//   is_mult      in   operation is mult
//   is_div       in   operation is div
//   operand_a    in   rs value
//   operand_b    in   rt value
//   rd_in        in   destination register
//   flush        in   abort any in-flight operation
//   unit_result  in   result from the mult/div unit
//   unit_except  in   overflow flag from the unit, sampled with the result
//   unit_ready   in   early completion (MULTDIV_EARLY_DONE_EN only)
//   op_a_q       out  latched operand A to the unit
//   op_b_q       out  latched operand B to the unit
//   start_mult   out  one-cycle start pulse, mult
//   start_div    out  one-cycle start pulse, div
//   stall        out  freeze PC and pipeline registers (combinational)
//   busy         out  sequencer is in RUN or DONE
//   wb_valid     out  one-cycle writeback beat
//   wb_data      out  result to write (0 on exception)
//   wb_rd        out  destination for wb_data
//   wb_rstatus   out  rstatus value, 0 = no exception
// -----------------------------------------------------------------------------
module multdiv_sequencer #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        issue_valid,
    input  logic        is_mult,
    input  logic        is_div,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [4:0]  rd_in,
    input  logic        flush,
    input  logic [31:0] unit_result,
    input  logic        unit_except,
`ifdef MULTDIV_EARLY_DONE_EN
    input  logic        unit_ready,
`endif
    output logic [31:0] op_a_q,
    output logic [31:0] op_b_q,
    output logic        start_mult,
    output logic        start_div,
    output logic        stall,
    output logic        busy,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_rstatus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter load values: RUN lasts N cycles, so the count starts at N-1
    // and completion happens on the edge where it reads zero.
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

    localparam logic [31:0] RSTATUS_NONE     = 32'd0;
    localparam logic [31:0] RSTATUS_MULT_OVF = 32'd4;
    localparam logic [31:0] RSTATUS_DIV_EXC  = 32'd5;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [31:0]       op_a_reg;
    logic [31:0]       op_b_reg;
    logic [4:0]        rd_reg;
    logic              op_is_div_reg;
    logic              start_mult_reg;
    logic              start_div_reg;
    logic              busy_reg;
    logic              wb_valid_reg;
    logic [31:0]       wb_data_reg;
    logic [4:0]        wb_rd_reg;
    logic [31:0]       wb_rstatus_reg;

    logic accept;
    logic div_by_zero;
    logic run_done;

    // A legal issue names exactly one operation; flush in IDLE wins over issue.
    assign accept      = issue_valid & (is_mult ^ is_div) & ~flush;
    assign div_by_zero = is_div & (operand_b == 32'd0);

`ifdef MULTDIV_EARLY_DONE_EN
    // The start pulse is high exactly in the first RUN cycle, so it doubles
    // as the "ignore unit_ready now" qualifier.
    logic first_run;
    assign first_run = start_mult_reg | start_div_reg;
    assign run_done  = (cnt_reg == '0) | (unit_ready & ~first_run);
`else
    assign run_done  = (cnt_reg == '0);
`endif

    // Stall covers the accept cycle (so upstream holds while we latch) and
    // every RUN cycle. Gated by reset_n so outputs are quiet during reset.
    assign stall = reset_n & ((state_reg == ST_RUN) |
                              ((state_reg == ST_IDLE) & accept));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            op_a_reg       <= '0;
            op_b_reg       <= '0;
            rd_reg         <= '0;
            op_is_div_reg  <= 1'b0;
            start_mult_reg <= 1'b0;
            start_div_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            wb_valid_reg   <= 1'b0;
            wb_data_reg    <= '0;
            wb_rd_reg      <= '0;
            wb_rstatus_reg <= '0;
        end else begin
            // Pulses default low; they are raised for a single cycle below.
            start_mult_reg <= 1'b0;
            start_div_reg  <= 1'b0;
            wb_valid_reg   <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        op_a_reg      <= operand_a;
                        op_b_reg      <= operand_b;
                        rd_reg        <= rd_in;
                        op_is_div_reg <= is_div;
                        busy_reg      <= 1'b1;
                        if (div_by_zero) begin
                            // Never bother the unit: report the exception now.
                            state_reg      <= ST_DONE;
                            wb_valid_reg   <= 1'b1;
                            wb_data_reg    <= 32'd0;
                            wb_rd_reg      <= rd_in;
                            wb_rstatus_reg <= RSTATUS_DIV_EXC;
                        end else begin
                            state_reg      <= ST_RUN;
                            cnt_reg        <= is_mult ? MULT_LAST : DIV_LAST;
                            start_mult_reg <= is_mult;
                            start_div_reg  <= is_div;
                        end
                    end
                end

                ST_RUN: begin
                    if (flush) begin
                        // Flush beats completion: drop the op silently.
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else if (run_done) begin
                        state_reg      <= ST_DONE;
                        wb_valid_reg   <= 1'b1;
                        wb_data_reg    <= unit_except ? 32'd0 : unit_result;
                        wb_rd_reg      <= rd_reg;
                        wb_rstatus_reg <= !unit_except ? RSTATUS_NONE :
                                          (op_is_div_reg ? RSTATUS_DIV_EXC
                                                         : RSTATUS_MULT_OVF);
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                ST_DONE: begin
                    // The beat lasts one cycle; any waiting issue is taken
                    // in the IDLE cycle that follows.
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end

                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign op_a_q     = op_a_reg;
    assign op_b_q     = op_b_reg;
    assign start_mult = start_mult_reg;
    assign start_div  = start_div_reg;
    assign busy       = busy_reg;
    assign wb_valid   = wb_valid_reg;
    assign wb_data    = wb_data_reg;
    assign wb_rd      = wb_rd_reg;
    assign wb_rstatus = wb_rstatus_reg;

endmodule

// File: tb/tb_multdiv_sequencer.sv
module tb_multdiv_sequencer;

    logic        clock;
    logic        reset_n;
    logic        issue_valid;
    logic        is_mult;
    logic        is_div;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  rd_in;
    logic        flush;
    logic [31:0] unit_result;
    logic        unit_except;
`ifdef MULTDIV_EARLY_DONE_EN
    logic        unit_ready;
`endif
    logic [31:0] op_a_q;
    logic [31:0] op_b_q;
    logic        start_mult;
    logic        start_div;
    logic        stall;
    logic        busy;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic [31:0] wb_rstatus;

    int checks;
    int failures;

    multdiv_sequencer #(
        .MULT_CYCLES(32),
        .DIV_CYCLES (32),
        .CNT_W      (6)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .issue_valid(issue_valid),
        .is_mult    (is_mult),
        .is_div     (is_div),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .rd_in      (rd_in),
        .flush      (flush),
        .unit_result(unit_result),
        .unit_except(unit_except),
`ifdef MULTDIV_EARLY_DONE_EN
        .unit_ready (unit_ready),
`endif
        .op_a_q     (op_a_q),
        .op_b_q     (op_b_q),
        .start_mult (start_mult),
        .start_div  (start_div),
        .stall      (stall),
        .busy       (busy),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd),
        .wb_rstatus (wb_rstatus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one op in the current cycle (cycle 1), then observe ncyc cycles.
    task automatic run_op(input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] res,
                          input logic exc, input int ncyc,
                          output int n_stall, output int n_smult,
                          output int n_sdiv, output int start_cyc,
                          output int n_wb, output int wb_cyc,
                          output logic [31:0] wdata, output logic [4:0] wrd,
                          output logic [31:0] wrs);
        n_stall = 0; n_smult = 0; n_sdiv = 0; start_cyc = -1;
        n_wb = 0; wb_cyc = -1; wdata = '0; wrd = '0; wrs = '0;
        unit_result = res;
        unit_except = exc;
        for (int c = 1; c <= ncyc; c++) begin
            if (c == 1) begin
                issue_valid = 1'b1; is_mult = m; is_div = d;
                operand_a = a; operand_b = b; rd_in = rd;
            end else begin
                issue_valid = 1'b0; is_mult = 1'b0; is_div = 1'b0;
            end
            #1;
            if (stall) n_stall++;
            if (start_mult) begin n_smult++; if (start_cyc < 0) start_cyc = c; end
            if (start_div)  begin n_sdiv++;  if (start_cyc < 0) start_cyc = c; end
            if (wb_valid) begin
                n_wb++; wb_cyc = c; wdata = wb_data; wrd = wb_rd; wrs = wb_rstatus;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; issue_valid = 1'b0; is_mult = 1'b0; is_div = 1'b0;
        operand_a = '0; operand_b = '0; rd_in = '0; flush = 1'b0;
        unit_result = '0; unit_except = 1'b0;
`ifdef MULTDIV_EARLY_DONE_EN
        unit_ready = 1'b0;
`endif
        step(); step();
        #2 reset_n = 1'b1;
        step();
        checks++;
        if ({op_a_q, op_b_q, start_mult, start_div, stall, busy, wb_valid,
             wb_data, wb_rd, wb_rstatus} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got nonzero outputs busy=%0b stall=%0b wb_valid=%0b, required all 0",
                     busy, stall, wb_valid);
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_mult();
        int ns, nm, nd, sc, nw, wc; logic [31:0] wd, wr; logic [4:0] wrd;
        run_op(1'b1, 1'b0, 32'd3, 32'd4, 5'd5, 32'd12, 1'b0, 36,
               ns, nm, nd, sc, nw, wc, wd, wrd, wr);
        checks++; if (ns !== 33) begin failures++; $display("FAIL mult_stall_cycles: got %0d, required 33", ns); end
        checks++; if (nm !== 1 || sc !== 2 || nd !== 0) begin failures++;
            $display("FAIL mult_start: got start_mult=%0d at cycle %0d start_div=%0d, required 1 at cycle 2 and 0", nm, sc, nd); end
        checks++; if (nw !== 1 || wc !== 34) begin failures++;
            $display("FAIL mult_wb_timing: got %0d beats last cycle %0d, required 1 at cycle 34", nw, wc); end
        checks++; if (wd !== 32'd12 || wrd !== 5'd5 || wr !== 32'd0) begin failures++;
            $display("FAIL mult_wb_value: got data=%0d rd=%0d rstatus=%0d, required 12 5 0", wd, wrd, wr); end
        checks++; if (op_a_q !== 32'd3 || op_b_q !== 32'd4) begin failures++;
            $display("FAIL mult_operands: got a=%0d b=%0d, required 3 4", op_a_q, op_b_q); end
        checks++; if (wb_valid !== 1'b0 || wb_data !== 32'd12) begin failures++;
            $display("FAIL wb_hold: got valid=%0b data=%0d, required 0 12", wb_valid, wb_data); end
        $display("mult 3*4: wb cycle %0d data %0d rd %0d rstatus %0d stall %0d", wc, wd, wrd, wr, ns);
    endtask

    task automatic test_div();
        int ns, nm, nd, sc, nw, wc; logic [31:0] wd, wr; logic [4:0] wrd;
        run_op(1'b0, 1'b1, 32'd100, 32'd7, 5'd13, 32'd14, 1'b0, 36,
               ns, nm, nd, sc, nw, wc, wd, wrd, wr);
        checks++; if (nd !== 1 || sc !== 2 || nm !== 0) begin failures++;
            $display("FAIL div_start: got start_div=%0d at cycle %0d start_mult=%0d, required 1 at cycle 2 and 0", nd, sc, nm); end
        checks++; if (nw !== 1 || wc !== 34 || wd !== 32'd14 || wrd !== 5'd13 || wr !== 32'd0) begin failures++;
            $display("FAIL div_wb: got n=%0d cyc=%0d data=%0d rd=%0d rs=%0d, required 1 34 14 13 0", nw, wc, wd, wrd, wr); end
        $display("div 100/7: wb cycle %0d data %0d rd %0d rstatus %0d", wc, wd, wrd, wr);
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1'b1, 36,
               ns, nm, nd, sc, nw, wc, wd, wrd, wr);
        checks++; if (nw !== 1 || wd !== 32'd0 || wr !== 32'd5 || wrd !== 5'd14) begin failures++;
            $display("FAIL div_except: got n=%0d data=%0d rs=%0d rd=%0d, required 1 0 5 14", nw, wd, wr, wrd); end
        $display("div overflow: data %0d rstatus %0d", wd, wr);
    endtask

    task automatic test_div_by_zero();
        int ns, nm, nd, sc, nw, wc; logic [31:0] wd, wr; logic [4:0] wrd;
        run_op(1'b0, 1'b1, 32'd7, 32'd0, 5'd11, 32'h1234, 1'b0, 4,
               ns, nm, nd, sc, nw, wc, wd, wrd, wr);
        checks++; if (nd !== 0 || nm !== 0) begin failures++;
            $display("FAIL dbz_no_start: got start_div=%0d start_mult=%0d, required 0 0", nd, nm); end
        checks++; if (ns !== 1) begin failures++; $display("FAIL dbz_stall: got %0d, required 1", ns); end
        checks++; if (nw !== 1 || wc !== 2 || wd !== 32'd0 || wr !== 32'd5 || wrd !== 5'd11) begin failures++;
            $display("FAIL dbz_wb: got n=%0d cyc=%0d data=%0d rs=%0d rd=%0d, required 1 2 0 5 11", nw, wc, wd, wr, wrd); end
        $display("div 7/0: wb cycle %0d data %0d rstatus %0d", wc, wd, wr);
    endtask

    task automatic test_mult_except();
        int ns, nm, nd, sc, nw, wc; logic [31:0] wd, wr; logic [4:0] wrd;
        run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2, 5'd12, 32'hFFFF_FFFE, 1'b1, 36,
               ns, nm, nd, sc, nw, wc, wd, wrd, wr);
        checks++; if (nw !== 1 || wc !== 34 || wd !== 32'd0 || wr !== 32'd4 || wrd !== 5'd12) begin failures++;
            $display("FAIL mult_except: got n=%0d cyc=%0d data=%0d rs=%0d rd=%0d, required 1 34 0 4 12", nw, wc, wd, wr, wrd); end
        $display("mult overflow: data %0d rstatus %0d", wd, wr);
    endtask

    task automatic test_illegal();
        int ns, nm, nd, sc, nw, wc; logic [31:0] wd, wr; logic [4:0] wrd;
        run_op(1'b1, 1'b1, 32'd1, 32'd1, 5'd1, 32'd1, 1'b0, 4,
               ns, nm, nd, sc, nw, wc, wd, wrd, wr);
        checks++; if (ns !== 0 || nw !== 0 || nm !== 0 || nd !== 0 || busy !== 1'b0) begin failures++;
            $display("FAIL illegal_issue: got stall=%0d wb=%0d sm=%0d sd=%0d busy=%0b, required all 0", ns, nw, nm, nd, busy); end
        $display("illegal issue: stall cycles %0d wb %0d", ns, nw);
    endtask

    task automatic test_flush();
        int ns, nm, nd, sc, nw, wc; logic [31:0] wd, wr; logic [4:0] wrd;
        int early_wb;
        early_wb = 0;
        unit_result = 32'd81; unit_except = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            issue_valid = (c == 1); is_mult = (c == 1); is_div = 1'b0;
            operand_a = 32'd9; operand_b = 32'd9; rd_in = 5'd3;
            flush = (c == 11);
            #1;
            if (wb_valid) early_wb++;
            if (c == 11) begin
                checks++; if (stall !== 1'b1) begin failures++;
                    $display("FAIL flush_run_stall: got %0b, required 1", stall); end
            end
            step();
        end
        flush = 1'b0;
        #1;
        checks++; if (stall !== 1'b0 || busy !== 1'b0 || wb_valid !== 1'b0 || early_wb !== 0) begin failures++;
            $display("FAIL flush_to_idle: got stall=%0b busy=%0b wb=%0b earlywb=%0d, required 0 0 0 0", stall, busy, wb_valid, early_wb); end
        $display("flush on 10th RUN cycle: stall %0b busy %0b", stall, busy);
        run_op(1'b1, 1'b0, 32'd2, 32'd5, 5'd8, 32'd10, 1'b0, 36,
               ns, nm, nd, sc, nw, wc, wd, wrd, wr);
        checks++; if (nw !== 1 || wc !== 34 || wd !== 32'd10 || wrd !== 5'd8 || ns !== 33) begin failures++;
            $display("FAIL flush_next_issue: got n=%0d cyc=%0d data=%0d rd=%0d stall=%0d, required 1 34 10 8 33", nw, wc, wd, wrd, ns); end
        $display("post-flush mult 2*5: wb cycle %0d data %0d rd %0d", wc, wd, wrd);
    endtask

    task automatic test_async_reset();
        int wb_seen, busy_seen;
        wb_seen = 0; busy_seen = 0;
        unit_result = 32'd1; unit_except = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            issue_valid = (c == 1); is_mult = (c == 1); is_div = 1'b0;
            operand_a = 32'd1; operand_b = 32'd1; rd_in = 5'd6;
            #1;
            if (c < 6) step();
        end
        checks++; if (busy !== 1'b1 || stall !== 1'b1) begin failures++;
            $display("FAIL areset_pre_busy: got busy=%0b stall=%0b, required 1 1", busy, stall); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({op_a_q, op_b_q, start_mult, start_div, stall, busy, wb_valid,
             wb_data, wb_rd, wb_rstatus} !== '0) begin
            failures++;
            $display("FAIL areset_outputs: got busy=%0b stall=%0b op_a=%0d wb_data=%0d, required all 0",
                     busy, stall, op_a_q, wb_data);
        end
        step(); step();
        #3 reset_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (wb_valid) wb_seen++;
            if (busy) busy_seen++;
        end
        checks++; if (wb_seen !== 0 || busy_seen !== 0) begin failures++;
            $display("FAIL areset_no_wb: got wb=%0d busy=%0d, required 0 0", wb_seen, busy_seen); end
        $display("async reset on 5th RUN cycle: wb after release %0d", wb_seen);
    endtask

    task automatic test_back_to_back();
        int nw, accept_cyc, ns;
        int wb_cyc[2]; logic [4:0] wb_rds[2]; logic [31:0] wb_dat[2];
        nw = 0; accept_cyc = -1; ns = 0;
        for (int i = 0; i < 2; i++) begin wb_cyc[i] = -1; wb_rds[i] = '0; wb_dat[i] = '0; end
        unit_except = 1'b0;
        for (int c = 1; c <= 72; c++) begin
            if (c == 1) begin
                issue_valid = 1'b1; is_mult = 1'b1; is_div = 1'b0;
                operand_a = 32'd6; operand_b = 32'd7; rd_in = 5'd7; unit_result = 32'd42;
            end else if (c <= 35) begin
                issue_valid = 1'b1; is_mult = 1'b0; is_div = 1'b1;
                operand_a = 32'd100; operand_b = 32'd7; rd_in = 5'd9;
            end else begin
                issue_valid = 1'b0; is_mult = 1'b0; is_div = 1'b0;
            end
            if (c == 35) unit_result = 32'd14;
            #1;
            if (stall) ns++;
            if (c >= 2 && stall && !busy && accept_cyc < 0) accept_cyc = c;
            if (wb_valid) begin
                if (nw < 2) begin wb_cyc[nw] = c; wb_rds[nw] = wb_rd; wb_dat[nw] = wb_data; end
                nw++;
            end
            step();
        end
        checks++; if (accept_cyc !== 35) begin failures++;
            $display("FAIL b2b_accept: got cycle %0d, required 35", accept_cyc); end
        checks++; if (nw !== 2 || ns !== 66) begin failures++;
            $display("FAIL b2b_counts: got wb=%0d stall=%0d, required 2 66", nw, ns); end
        checks++; if (wb_cyc[0] !== 34 || wb_rds[0] !== 5'd7 || wb_dat[0] !== 32'd42) begin failures++;
            $display("FAIL b2b_first: got cyc=%0d rd=%0d data=%0d, required 34 7 42", wb_cyc[0], wb_rds[0], wb_dat[0]); end
        checks++; if (wb_cyc[1] !== 68 || wb_rds[1] !== 5'd9 || wb_dat[1] !== 32'd14) begin failures++;
            $display("FAIL b2b_second: got cyc=%0d rd=%0d data=%0d, required 68 9 14", wb_cyc[1], wb_rds[1], wb_dat[1]); end
        $display("back-to-back: wb cycles %0d/%0d rd %0d/%0d", wb_cyc[0], wb_cyc[1], wb_rds[0], wb_rds[1]);
    endtask

`ifdef MULTDIV_EARLY_DONE_EN
    task automatic test_early_done();
        int ns, nw, wc; logic [31:0] wd;
        ns = 0; nw = 0; wc = -1; wd = '0;
        unit_result = 32'd25; unit_except = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            issue_valid = (c == 1); is_mult = (c == 1); is_div = 1'b0;
            operand_a = 32'd5; operand_b = 32'd5; rd_in = 5'd2;
            // First-RUN-cycle ready must be ignored; 4th RUN cycle ends it.
            unit_ready = (c == 2) || (c == 5);
            #1;
            if (stall) ns++;
            if (wb_valid) begin nw++; wc = c; wd = wb_data; end
            step();
        end
        unit_ready = 1'b0;
        checks++; if (ns !== 5 || nw !== 1 || wc !== 6 || wd !== 32'd25) begin failures++;
            $display("FAIL early_done: got stall=%0d wb=%0d cyc=%0d data=%0d, required 5 1 6 25", ns, nw, wc, wd); end
        $display("early done: stall %0d wb cycle %0d data %0d", ns, wc, wd);
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_mult();
        test_div();
        test_div_by_zero();
        test_mult_except();
        test_illegal();
        test_flush();
        test_async_reset();
        test_back_to_back();
`ifdef MULTDIV_EARLY_DONE_EN
        test_early_done();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
